// File: rtl/fetch_entry_packer.sv
// Fetch entry packer: turns aligned 32-bit fetch words into RVC / 32-bit
// instruction entries. It stitches instructions that straddle a word
// boundary and queues the entries in a small FIFO toward decode.
module fetch_entry_packer #(
    parameter int VLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [31:0]     mem_data_i,
    input  logic [VLEN-1:0] mem_addr_i,
    input  logic            mem_ex_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [31:0]     fetch_instr_o,
    output logic [VLEN-1:0] fetch_addr_o,
    output logic            fetch_ex_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]     instr_q [DEPTH];
    logic [VLEN-1:0] addr_q  [DEPTH];
    logic [DEPTH-1:0] ex_q;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            pend_valid;
    logic [15:0]     pend_half;
    logic [VLEN-1:0] pend_addr;
    logic            pend_valid_nxt;
    logic [15:0]     pend_half_nxt;
    logic [VLEN-1:0] pend_addr_nxt;

    logic [31:0]     hold_instr;
    logic [VLEN-1:0] hold_addr;
    logic            hold_ex;

    logic            accept;
    logic            pop;
    logic            do_upper;
    logic [1:0]      n_push;
    logic [31:0]     push_instr [2];
    logic [VLEN-1:0] push_addr  [2];
    logic [1:0]      push_ex;

    logic [15:0]     lo_half;
    logic [15:0]     hi_half;
    logic [VLEN-1:0] hi_addr;

    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    // Two free slots are always kept in reserve so a word can push two entries.
    assign mem_ready_o   = (count <= CW'(DEPTH - 2)) && !flush_i;
    assign accept        = mem_valid_i && mem_ready_o;
    assign fetch_valid_o = (count != '0);
    assign pop           = fetch_valid_o && fetch_ready_i;

    assign lo_half = mem_data_i[15:0];
    assign hi_half = mem_data_i[31:16];
    // The upper half always lives at word base + 2, whatever the start offset.
    assign hi_addr = {mem_addr_i[VLEN-1:2], 2'b10};

    // When the FIFO is empty the head shows the last entry it presented.
    assign fetch_instr_o = fetch_valid_o ? instr_q[rd_ptr] : hold_instr;
    assign fetch_addr_o  = fetch_valid_o ? addr_q[rd_ptr]  : hold_addr;
    assign fetch_ex_o    = fetch_valid_o ? ex_q[rd_ptr]    : hold_ex;

    // Split the accepted word into up to two entries, in program order.
    always_comb begin
        n_push         = 2'd0;
        do_upper       = 1'b0;
        push_instr[0]  = '0;
        push_instr[1]  = '0;
        push_addr[0]   = '0;
        push_addr[1]   = '0;
        push_ex        = '0;
        pend_valid_nxt = pend_valid;
        pend_half_nxt  = pend_half;
        pend_addr_nxt  = pend_addr;
        if (accept) begin
            if (mem_ex_i) begin
                // A faulting word is never decoded; it carries one marker entry.
                push_addr[0]   = pend_valid ? pend_addr : mem_addr_i;
                push_ex[0]     = 1'b1;
                n_push         = 2'd1;
                pend_valid_nxt = 1'b0;
            end else begin
                pend_valid_nxt = 1'b0;
                do_upper       = 1'b1;
                if (pend_valid && !mem_addr_i[1]) begin
                    push_instr[0] = {lo_half, pend_half};
                    push_addr[0]  = pend_addr;
                    n_push        = 2'd1;
                end else if (!mem_addr_i[1]) begin
                    push_addr[0] = mem_addr_i;
                    n_push       = 2'd1;
                    if (is_rvc(lo_half)) begin
                        push_instr[0] = {16'h0000, lo_half};
                    end else begin
                        push_instr[0] = mem_data_i;
                        do_upper      = 1'b0;
                    end
                end
                // An unaligned start with a pending half is a frontend bug; the half is dropped.
                if (do_upper) begin
                    if (is_rvc(hi_half)) begin
                        push_instr[n_push[0]] = {16'h0000, hi_half};
                        push_addr[n_push[0]]  = hi_addr;
                        n_push                = n_push + 2'd1;
                    end else begin
                        pend_valid_nxt = 1'b1;
                        pend_half_nxt  = hi_half;
                        pend_addr_nxt  = hi_addr;
                    end
                end
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ex_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                addr_q[i]  <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (n_push != 2'd0) begin
                instr_q[wr_ptr] <= push_instr[0];
                addr_q[wr_ptr]  <= push_addr[0];
                ex_q[wr_ptr]    <= push_ex[0];
            end
            if (n_push == 2'd2) begin
                instr_q[wr_ptr + PW'(1)] <= push_instr[1];
                addr_q[wr_ptr + PW'(1)]  <= push_addr[1];
                ex_q[wr_ptr + PW'(1)]    <= push_ex[1];
            end
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Pending lower half of a word-straddling 32-bit instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_valid <= 1'b0;
            pend_half  <= '0;
            pend_addr  <= '0;
        end else if (flush_i) begin
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= pend_valid_nxt;
            pend_half  <= pend_half_nxt;
            pend_addr  <= pend_addr_nxt;
        end
    end

    // Remember the presented head so it stays visible once the FIFO drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_instr <= '0;
            hold_addr  <= '0;
            hold_ex    <= 1'b0;
        end else if (fetch_valid_o) begin
            hold_instr <= instr_q[rd_ptr];
            hold_addr  <= addr_q[rd_ptr];
            hold_ex    <= ex_q[rd_ptr];
        end
    end

    // Occupancy after this cycle's pushes and pop must never exceed DEPTH.
    assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, count} + {{(CW-1){1'b0}}, n_push}) <= ((CW+1)'(DEPTH) + {{CW{1'b0}}, pop}));

endmodule

// File: tb/tb_fetch_entry_packer.sv
// Bench for fetch_entry_packer: directed cases and randomized word streams.
// A halfword-level reference model predicts the entries into a queue, and a
// monitor compares them with every entry that decode accepts.
module tb_fetch_entry_packer;

    localparam int VLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_data;
    logic [VLEN-1:0] mem_addr;
    logic            mem_ex;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_instr;
    logic [VLEN-1:0] fetch_addr;
    logic            fetch_ex;

    always #5 clk = ~clk;

    fetch_entry_packer #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .mem_valid_i  (mem_valid),
        .mem_ready_o  (mem_ready),
        .mem_data_i   (mem_data),
        .mem_addr_i   (mem_addr),
        .mem_ex_i     (mem_ex),
        .fetch_valid_o(fetch_valid),
        .fetch_ready_i(fetch_ready),
        .fetch_instr_o(fetch_instr),
        .fetch_addr_o (fetch_addr),
        .fetch_ex_o   (fetch_ex)
    );

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            ex;
    } entry_t;

    entry_t exp_q[$];
    entry_t mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    bit              m_pend_v = 1'b0;
    logic [15:0]     m_pend_h;
    logic [VLEN-1:0] m_pend_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic entry_t mk(input logic [31:0] i, input logic [VLEN-1:0] a, input logic e);
        entry_t r;
        r.instr = i;
        r.addr  = a;
        r.ex    = e;
        return r;
    endfunction

    // Reference: walk the word as a stream of halfwords from its start offset.
    task automatic model_word(input logic [31:0] d, input logic [VLEN-1:0] a, input logic e);
        int h;
        logic [15:0] half;
        logic [VLEN-1:0] ha;
        if (e) begin
            exp_q.push_back(mk(32'h0, m_pend_v ? m_pend_a : a, 1'b1));
            m_pend_v = 1'b0;
            return;
        end
        h = int'(a[1]);
        while (h < 2) begin
            half = d[16*h +: 16];
            ha   = {a[VLEN-1:2], h[0], 1'b0};
            if (m_pend_v) begin
                exp_q.push_back(mk({half, m_pend_h}, m_pend_a, 1'b0));
                m_pend_v = 1'b0;
                h++;
            end else if (half[1:0] != 2'b11) begin
                exp_q.push_back(mk({16'h0, half}, ha, 1'b0));
                h++;
            end else if (h == 0) begin
                exp_q.push_back(mk(d, ha, 1'b0));
                h = 2;
            end else begin
                m_pend_v = 1'b1;
                m_pend_h = half;
                m_pend_a = ha;
                h++;
            end
        end
    endtask

    // Scoreboard producer: runs just after the monitor on each falling edge.
    always @(negedge clk) begin
        #1;
        if (rst || flush) begin
            exp_q.delete();
            m_pend_v = 1'b0;
        end else if (mem_valid && mem_ready) begin
            model_word(mem_data, mem_addr, mem_ex);
        end
    end

    // Monitor: compare every entry that decode takes.
    always @(negedge clk) begin
        if (!rst && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_entry: got instr %0h addr %0h, expected none", fetch_instr, fetch_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("entry_instr", fetch_instr, mon_e.instr);
                chk("entry_addr", fetch_addr, mon_e.addr);
                chk("entry_ex", fetch_ex, mon_e.ex);
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [VLEN-1:0] a, input logic e);
        bit acc = 1'b0;
        int t = 0;
        mem_valid = 1'b1;
        mem_data  = d;
        mem_addr  = a;
        mem_ex    = e;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = mem_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        mem_valid = 1'b0;
        mem_ex    = 1'b0;
    endtask

    task automatic drain(input int budget);
        fetch_ready = 1'b1;
        for (int t = 0; t < budget && (exp_q.size() != 0 || fetch_valid); t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_valid_low", 64'(fetch_valid), 64'd0);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 64'(mem_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit need_new;
        bit after_flush;
        bit acc;
        bit fl;
        logic [15:0] lo_h;
        logic [15:0] hi_h;
        logic [VLEN-1:0] a;
        logic e;

        rst = 1'b1;
        flush = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        mem_addr = '0;
        mem_ex = 1'b0;
        fetch_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(fetch_valid), 64'd0);
        chk("reset_instr", 64'(fetch_instr), 64'd0);
        chk("reset_addr", fetch_addr, 64'd0);
        chk("reset_ex", 64'(fetch_ex), 64'd0);
        chk("reset_mem_ready", 64'(mem_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single 32-bit instruction, visible the cycle after acceptance.
        fetch_ready = 1'b1;
        send_word(32'h00130293, 64'h80000000, 1'b0);
        chk("latency_valid", 64'(fetch_valid), 64'd1);
        drain(20);

        // Two RVC halves, then a straddling 32-bit instruction.
        send_word(32'h40014501, 64'h80000000, 1'b0);
        drain(20);
        send_word(32'h02934501, 64'h80000000, 1'b0);
        send_word(32'h45050013, 64'h80000004, 1'b0);
        drain(20);

        // Back-pressure: two RVC pairs fill DEPTH=4.
        fetch_ready = 1'b0;
        send_word(32'h40014501, 64'h80000010, 1'b0);
        send_word(32'h40014501, 64'h80000014, 1'b0);
        @(negedge clk);
        chk("full_ready_low", 64'(mem_ready), 64'd0);
        chk("full_valid", 64'(fetch_valid), 64'd1);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data = 32'h40014501;
        mem_addr = 64'h80000018;
        repeat (3) @(posedge clk);
        #1;
        fetch_ready = 1'b1;
        send_word(32'h40014501, 64'h80000018, 1'b0);
        drain(20);
        chk("ready_back", 64'(mem_ready), 64'd1);

        // Flush drops a pending upper half.
        send_word(32'h02930000, 64'h80000002, 1'b0);
        flush_pulse();
        send_word(32'h4501beef, 64'h80000102, 1'b0);
        drain(20);

        // Exception word while a half is pending, then a clean word.
        send_word(32'h02930000, 64'h80000002, 1'b0);
        send_word(32'hdeadbeef, 64'h80000004, 1'b1);
        drain(20);
        send_word(32'h00014501, 64'h80000008, 1'b0);
        drain(20);

        // Randomized stream with back-pressure, exceptions and flushes.
        flush_pulse();
        need_new = 1'b1;
        after_flush = 1'b1;
        a = '0;
        for (int c = 0; c < 3000; c++) begin
            if (need_new) begin
                lo_h = 16'($urandom);
                hi_h = 16'($urandom);
                if ($urandom_range(0, 1) == 0) lo_h[1:0] = 2'($urandom_range(0, 2));
                else lo_h[1:0] = 2'b11;
                if ($urandom_range(0, 1) == 0) hi_h[1:0] = 2'($urandom_range(0, 2));
                else hi_h[1:0] = 2'b11;
                e = ($urandom_range(0, 19) == 0);
                if (after_flush) begin
                    a = 64'h80000000 + 64'($urandom_range(0, 255) * 4) + 64'($urandom_range(0, 1) * 2);
                    after_flush = 1'b0;
                end else begin
                    a = (a & ~64'd3) + 64'd4;
                end
                need_new = 1'b0;
            end
            mem_data = {hi_h, lo_h};
            mem_addr = a;
            mem_ex = e;
            mem_valid = ($urandom_range(0, 3) != 0);
            fetch_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            acc = mem_valid && mem_ready;
            fl = flush;
            @(posedge clk);
            #1;
            if (fl) begin
                after_flush = 1'b1;
                need_new = 1'b1;
            end else if (acc) begin
                need_new = 1'b1;
            end
        end
        flush = 1'b0;
        mem_valid = 1'b0;
        mem_ex = 1'b0;
        drain(100);

        // Reset in the middle of traffic.
        fetch_ready = 1'b0;
        send_word(32'h40014501, 64'h80000200, 1'b0);
        send_word(32'h00130293, 64'h80000204, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_valid", 64'(fetch_valid), 64'd0);
        chk("midreset_instr", 64'(fetch_instr), 64'd0);
        chk("midreset_addr", fetch_addr, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_mem_ready", 64'(mem_ready), 64'd1);
        @(posedge clk);
        #1;
        send_word(32'h45050013, 64'h80000300, 1'b0);
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
